// File: rtl/irrigation_sequencer.sv
// Watering-cycle sequencer: latches a BCD MM:SS preset, drives the valve while
// counting down on a 1 Hz tick, and handles soil-wet abort, error fault and lockout.
module irrigation_sequencer #(
    parameter int COOLDOWN_S = 10,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       auto_en,
    input  logic       start_req,
    input  logic       soil_wet,
    input  logic       error,
    input  logic       fault_clr,
    input  logic [3:0] pre_dm,
    input  logic [3:0] pre_um,
    input  logic [3:0] pre_ds,
    input  logic [3:0] pre_us,
    output logic [3:0] cnt_dm,
    output logic [3:0] cnt_um,
    output logic [3:0] cnt_ds,
    output logic [3:0] cnt_us,
    output logic       valve,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        COOL  = 3'd3,
        FAULT = 3'd4
    } stateT;

    localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN_S);

    stateT           stateReg, stateNext;
    logic [3:0][3:0] cntReg, cntNext, decVal, presetVal;
    logic [CW-1:0]   coolReg, coolNext;
    logic            doneNext, abortNext;
    logic            presetZero, presetValid, borrow;

    // Digit order: [3]=tens of minutes, [2]=minutes, [1]=tens of seconds, [0]=seconds
    assign presetVal   = {pre_dm, pre_um, pre_ds, pre_us};
    assign presetZero  = (presetVal == '0);
    assign presetValid = (pre_dm <= 4'd9) && (pre_um <= 4'd9) &&
                         (pre_ds <= 4'd5) && (pre_us <= 4'd9);

    // One-second BCD decrement; tens-of-seconds wraps to 5 rather than 9
    always_comb begin
        decVal = cntReg;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (cntReg[i] == 4'd0) begin
                    decVal[i] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    decVal[i] = cntReg[i] - 4'd1;
                    borrow    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        coolNext  = coolReg;
        doneNext  = 1'b0;
        abortNext = 1'b0;
        case (stateReg)
            IDLE: begin
                cntNext = '0;
                if (error) begin
                    stateNext = FAULT;
                end else if (auto_en && start_req && !soil_wet && !presetZero) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                if (error) begin
                    stateNext = FAULT;
                end else if (!auto_en) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (!presetValid) begin
                    stateNext = FAULT;
                    cntNext   = '0;
                end else begin
                    stateNext = RUN;
                    cntNext   = presetVal;
                end
            end
            RUN: begin
                if (error) begin
                    stateNext = FAULT;
                end else if (!auto_en) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (soil_wet) begin
                    stateNext = COOL;
                    coolNext  = COOL_INIT;
                    abortNext = 1'b1;
                end else if (tick) begin
                    if ((cntReg == '0) || (decVal == '0)) begin
                        stateNext = COOL;
                        cntNext   = '0;
                        coolNext  = COOL_INIT;
                        doneNext  = 1'b1;
                    end else begin
                        cntNext = decVal;
                    end
                end
            end
            COOL: begin
                if (error) begin
                    stateNext = FAULT;
                end else if (!auto_en) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (tick) begin
                    if (coolReg <= CW'(1)) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                        coolNext  = '0;
                    end else begin
                        coolNext = coolReg - CW'(1);
                    end
                end
            end
            FAULT: begin
                if (fault_clr && !error) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with the state output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            coolReg  <= '0;
            valve    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            fault    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            coolReg  <= coolNext;
            valve    <= (stateNext == RUN);
            busy     <= (stateNext == LOAD) || (stateNext == RUN);
            done     <= doneNext;
            aborted  <= abortNext;
            fault    <= (stateNext == FAULT);
        end
    end

    assign state  = stateReg;
    assign cnt_dm = cntReg[3];
    assign cnt_um = cntReg[2];
    assign cnt_ds = cntReg[1];
    assign cnt_us = cntReg[0];

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
- Sequences one watering cycle of the irrigation timer: latches the 4-digit BCD MM:SS preset produced by the timer-preset logic, opens the valve, and counts down on a 1 Hz tick.
- Handles sensor abort, error fault and a post-run lockout.
- Sits between the sensor/preset logic and the valve driver and display decoders.
- Single clock domain; all outputs are registered.

Parameters:
COOLDOWN_S, 10, lockout length in ticks after a run ends or aborts (1..255)
CW, 8, width of the cooldown counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle 1 Hz enable pulse, synchronous to clk
auto_en  in  1  automatic mode enabled (M)
start_req  in  1  watering demand level
soil_wet  in  1  soil-humidity-satisfied sensor (Us)
error  in  1  sensor/system error
fault_clr  in  1  one-cycle fault acknowledge
pre_dm, pre_um, pre_ds, pre_us  in  4 each  BCD preset digits (tens min, units min, tens sec, units sec)
cnt_dm, cnt_um, cnt_ds, cnt_us  out  4 each  current BCD countdown for display
valve  out  1  valve/pump drive
busy  out  1  high in LOAD or RUN
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on soil_wet abort
fault  out  1  high in FAULT
state  out  3  IDLE=0, LOAD=1, RUN=2, COOL=3, FAULT=4

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all cnt_* cleared to 0; cooldown counter cleared; valve=0; busy=0; done=0; aborted=0; fault=0.
- Input priority, evaluated every cycle in every state: error > auto_en=0 > soil_wet > tick.
- error=1 in any state other than FAULT: next state FAULT; valve=0 from the next cycle.
- IDLE:
  - cnt_* hold 0.
  - Go to LOAD when auto_en & start_req & !soil_wet & !error and the preset is not 00:00.
  - A zero preset keeps the block in IDLE.
- LOAD (exactly 1 cycle):
  - Capture pre_* into cnt_*.
  - Any invalid digit (dm/um/us > 9, ds > 5) -> FAULT, and cnt_* are cleared.
  - Otherwise -> RUN; valve=1 from the first RUN cycle.
  - A tick in LOAD is ignored.
- RUN: valve=1, busy=1. On tick:
  - Decrement MM:SS in BCD.
  - us 0 -> 9 with borrow; ds 0 -> 5 with borrow; um 0 -> 9 with borrow; dm decrements.
  - Each digit stays within 0..9, except ds, which stays within 0..5.
  - A tick at 00:01 -> cnt becomes 00:00; state -> COOL; done=1 for 1 cycle; valve=0 the same cycle cnt shows 00:00.
- RUN with soil_wet=1: -> COOL; aborted=1 for 1 cycle; cnt_* retain the remaining time; no decrement that cycle even if tick=1.
- RUN with auto_en=0: -> IDLE; cnt_* cleared; no done, no aborted.
- COOL:
  - valve=0.
  - Cooldown counter is loaded with COOLDOWN_S on entry and decremented on each tick.
  - -> IDLE on the tick that reaches 0; cnt_* cleared on exit.
  - start_req is ignored; auto_en=0 -> IDLE immediately.
- FAULT:
  - valve=0, fault=1; cnt_* hold their value.
  - -> IDLE only when fault_clr=1 & error=0 in the same cycle; fault_clr while error=1 is ignored.
- done and aborted are never both asserted in the same cycle; each is high for exactly 1 cycle per event.
- start_req held high across COOL retriggers a new LOAD on the first eligible IDLE cycle, i.e. the cycle after COOL exits.

Test Plan:
- Preset 01:05, auto_en=1, start_req=1 -> LOAD then RUN, valve=1; after 5 ticks cnt=01:00; next tick cnt=00:59; after 65 ticks total cnt=00:00, done pulses once, valve=0, state=COOL; after 10 further ticks state=IDLE.
- Preset 00:30, start run; after 12 ticks raise soil_wet -> aborted pulse, cnt holds 00:18, valve=0 next cycle, state=COOL, no done.
- Preset 05:00, error=1 mid-RUN -> FAULT, valve=0, fault=1; fault_clr with error=1 -> stays FAULT; error=0 then fault_clr -> IDLE.
- Preset ds=6 (00:60) or us=0xA -> LOAD -> FAULT, cnt=00:00, valve never asserts.
- Preset 00:00 with start_req=1 -> remains IDLE, valve=0; start_req during COOL -> no LOAD until COOL exits.
- rst_n low mid-RUN at cnt 02:37 -> immediately valve=0, cnt=00:00, state=IDLE; after release with start_req=1 the block reloads the preset normally.
